// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back / write-allocate data cache with a request/grant line-swap engine.
// Build option: define CACHE_LRU_EN for true-LRU replacement; otherwise a per-set FIFO pointer is used.
module set_assoc_cache #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 3,
    parameter int TAG_ADDR_LEN  = 6,
    parameter int WAY_CNT       = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [31:0]                            addr,
    input  logic                                   rd_req,
    input  logic [3:0]                             wr_be,
    input  logic [31:0]                            wr_data,
    output logic [31:0]                            rd_data,
    output logic                                   miss,
    output logic                                   mem_rd_req,
    output logic                                   mem_wr_req,
    output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0]   mem_addr,
    output logic [(32<<LINE_ADDR_LEN)-1:0]         mem_wr_line,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]         mem_rd_line,
    input  logic                                   mem_gnt
);

    localparam int LINE_SIZE    = 1 << LINE_ADDR_LEN;
    localparam int SET_CNT      = 1 << SET_ADDR_LEN;
    localparam int MEM_ADDR_LEN = TAG_ADDR_LEN + SET_ADDR_LEN + LINE_ADDR_LEN;
    localparam int WAY_ADDR_LEN = $clog2(WAY_CNT);
    localparam int LINE_BITS    = 32 * LINE_SIZE;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SWAP_OUT   = 2'd1,
        SWAP_IN    = 2'd2,
        SWAP_IN_OK = 2'd3
    } state_t;

    logic [LINE_ADDR_LEN-1:0] offset_s;
    logic [SET_ADDR_LEN-1:0]  set_s;
    logic [TAG_ADDR_LEN-1:0]  tag_s;
    logic                     unused_addr_s;

    logic                     valid_r [WAY_CNT][SET_CNT];
    logic                     dirty_r [WAY_CNT][SET_CNT];
    logic [TAG_ADDR_LEN-1:0]  tag_r   [WAY_CNT][SET_CNT];
    logic [31:0]              data_r  [WAY_CNT][SET_CNT][LINE_SIZE];

    logic [WAY_CNT-1:0]       match_s;
    logic                     hit_s;
    logic [WAY_ADDR_LEN-1:0]  hit_way_s;
    logic                     req_s;
    logic                     write_hit_s;
    logic                     fill_s;

    state_t                   state_r;
    state_t                   next_state_s;
    logic [WAY_ADDR_LEN-1:0]  victim_s;
    logic [WAY_ADDR_LEN-1:0]  victim_way_r;
    logic [TAG_ADDR_LEN-1:0]  req_tag_r;
    logic [SET_ADDR_LEN-1:0]  req_set_r;
    logic [LINE_BITS-1:0]     fill_line_r;
    logic                     miss_detect_s;

    logic [SET_ADDR_LEN-1:0]  cur_set_s;
    logic [TAG_ADDR_LEN-1:0]  cur_tag_s;
    logic [WAY_ADDR_LEN-1:0]  sel_way_s;
    logic [LINE_BITS-1:0]     victim_line_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return merged;
    endfunction

    assign offset_s      = addr[LINE_ADDR_LEN+1:2];
    assign set_s         = addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
    assign tag_s         = addr[MEM_ADDR_LEN+1:LINE_ADDR_LEN+SET_ADDR_LEN+2];
    assign unused_addr_s = ^{addr[31:MEM_ADDR_LEN+2], addr[1:0]};

    assign req_s         = rd_req | (|wr_be);
    assign write_hit_s   = (state_r == IDLE) & hit_s & (|wr_be);
    assign fill_s        = (state_r == SWAP_IN_OK);
    assign miss_detect_s = (state_r == IDLE) & req_s & ~hit_s;

    assign miss    = req_s & ((state_r != IDLE) | ~hit_s);
    assign rd_data = (hit_s & rd_req) ? data_r[hit_way_s][set_s][offset_s] : 32'h0000_0000;

    // Tag compare across all ways of the addressed set; tags within a set are unique, so OR-encoding is safe
    always_comb begin
        match_s   = '0;
        hit_way_s = '0;
        for (int w = 0; w < WAY_CNT; w++) begin
            match_s[w] = valid_r[w][set_s] & (tag_r[w][set_s] == tag_s);
            hit_way_s  = hit_way_s | (match_s[w] ? WAY_ADDR_LEN'(w) : '0);
        end
        hit_s = |match_s;
    end

`ifdef CACHE_LRU_EN
    logic [WAY_ADDR_LEN-1:0] age_r [WAY_CNT][SET_CNT];
    logic                    touch_s;
    logic [WAY_ADDR_LEN-1:0] touch_way_s;
    logic [SET_ADDR_LEN-1:0] touch_set_s;
    logic [WAY_ADDR_LEN-1:0] touch_age_s;

    assign touch_s     = ((state_r == IDLE) & hit_s & req_s) | fill_s;
    assign touch_way_s = fill_s ? victim_way_r : hit_way_s;
    assign touch_set_s = fill_s ? req_set_r : set_s;
    assign touch_age_s = age_r[touch_way_s][touch_set_s];

    // Victim is the oldest way of the addressed set
    always_comb begin
        victim_s = '0;
        for (int w = 0; w < WAY_CNT; w++) begin
            victim_s = victim_s | ((age_r[w][set_s] == WAY_ADDR_LEN'(WAY_CNT - 1)) ? WAY_ADDR_LEN'(w) : '0);
        end
    end

    // Age update: touched way becomes youngest, younger ways age by one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < WAY_CNT; w++) begin
                for (int s = 0; s < SET_CNT; s++) begin
                    age_r[w][s] <= WAY_ADDR_LEN'(w);
                end
            end
        end else if (touch_s) begin
            for (int w = 0; w < WAY_CNT; w++) begin
                if (WAY_ADDR_LEN'(w) == touch_way_s) begin
                    age_r[w][touch_set_s] <= '0;
                end else if (age_r[w][touch_set_s] < touch_age_s) begin
                    age_r[w][touch_set_s] <= age_r[w][touch_set_s] + 1'b1;
                end
            end
        end
    end
`else
    logic [WAY_ADDR_LEN-1:0] fifo_ptr_r [SET_CNT];

    assign victim_s = fifo_ptr_r[set_s];

    // Per-set FIFO pointer advances on every fill and wraps naturally at WAY_CNT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SET_CNT; s++) begin
                fifo_ptr_r[s] <= '0;
            end
        end else if (fill_s) begin
            fifo_ptr_r[req_set_r] <= fifo_ptr_r[req_set_r] + 1'b1;
        end
    end
`endif

    // Line metadata: valid/dirty/tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < WAY_CNT; w++) begin
                for (int s = 0; s < SET_CNT; s++) begin
                    valid_r[w][s] <= 1'b0;
                    dirty_r[w][s] <= 1'b0;
                    tag_r[w][s]   <= '0;
                end
            end
        end else if (fill_s) begin
            valid_r[victim_way_r][req_set_r] <= 1'b1;
            dirty_r[victim_way_r][req_set_r] <= 1'b0;
            tag_r[victim_way_r][req_set_r]   <= req_tag_r;
        end else if (write_hit_s) begin
            dirty_r[hit_way_s][set_s] <= 1'b1;
        end
    end

    // Line data storage, intentionally without reset
    always_ff @(posedge clk) begin
        if (fill_s) begin
            for (int k = 0; k < LINE_SIZE; k++) begin
                data_r[victim_way_r][req_set_r][k] <= fill_line_r[32*k +: 32];
            end
        end else if (write_hit_s) begin
            data_r[hit_way_s][set_s][offset_s] <= merge_bytes(data_r[hit_way_s][set_s][offset_s], wr_data, wr_be);
        end
    end

    // Swap FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (miss_detect_s) begin
                    next_state_s = (valid_r[victim_s][set_s] & dirty_r[victim_s][set_s]) ? SWAP_OUT : SWAP_IN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SWAP_OUT: begin
                if (mem_gnt) begin
                    next_state_s = SWAP_IN;
                end else begin
                    next_state_s = SWAP_OUT;
                end
            end
            SWAP_IN: begin
                if (mem_gnt) begin
                    next_state_s = SWAP_IN_OK;
                end else begin
                    next_state_s = SWAP_IN;
                end
            end
            SWAP_IN_OK: next_state_s = IDLE;
            default:    next_state_s = IDLE;
        endcase
    end

    // Swap FSM state plus the request context captured when the miss is first seen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            victim_way_r <= '0;
            req_tag_r    <= '0;
            req_set_r    <= '0;
            fill_line_r  <= '0;
        end else begin
            state_r <= next_state_s;
            if (miss_detect_s) begin
                victim_way_r <= victim_s;
                req_tag_r    <= tag_s;
                req_set_r    <= set_s;
            end
            if ((state_r == SWAP_IN) && mem_gnt) begin
                fill_line_r <= mem_rd_line;
            end
        end
    end

    // In IDLE the live request drives the swap context; afterwards the latched copy does
    always_comb begin
        cur_set_s     = (state_r == IDLE) ? set_s : req_set_r;
        cur_tag_s     = (state_r == IDLE) ? tag_s : req_tag_r;
        sel_way_s     = (state_r == IDLE) ? victim_s : victim_way_r;
        victim_line_s = '0;
        for (int k = 0; k < LINE_SIZE; k++) begin
            victim_line_s[32*k +: 32] = data_r[sel_way_s][cur_set_s][k];
        end
    end

    // Memory-side outputs are registered decodes of the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wr_req  <= 1'b0;
            mem_rd_req  <= 1'b0;
            mem_addr    <= '0;
            mem_wr_line <= '0;
        end else begin
            mem_wr_req <= (next_state_s == SWAP_OUT);
            mem_rd_req <= (next_state_s == SWAP_IN);
            case (next_state_s)
                SWAP_OUT: begin
                    mem_addr    <= {tag_r[sel_way_s][cur_set_s], cur_set_s};
                    mem_wr_line <= victim_line_s;
                end
                SWAP_IN: begin
                    mem_addr    <= {cur_tag_s, cur_set_s};
                    mem_wr_line <= '0;
                end
                default: begin
                    mem_addr    <= '0;
                    mem_wr_line <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench for set_assoc_cache: directed accesses push expectations, a negedge monitor pops and compares.
module tb_set_assoc_cache;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic         rd_req;
    logic [3:0]   wr_be;
    logic [31:0]  wr_data;
    logic [31:0]  rd_data;
    logic         miss;
    logic         mem_rd_req;
    logic         mem_wr_req;
    logic [8:0]   mem_addr;
    logic [255:0] mem_wr_line;
    logic [255:0] mem_rd_line;
    logic         mem_gnt;

    typedef struct {
        logic [31:0] data;
        int          miss_cycles;
    } rsp_t;

    typedef struct {
        logic         wr;
        logic [8:0]   laddr;
        logic [255:0] line;
    } mreq_t;

    rsp_t         rsp_q[$];
    mreq_t        mreq_q[$];
    int           total = 0;
    int           bad = 0;
    int           miss_cnt = 0;
    int           gnt_delay = 2;
    int           wait_cnt = 0;
    logic [255:0] mem_arr [512];
    logic         prev_rd = 1'b0;
    logic         prev_wr = 1'b0;
    logic [255:0] exp_line;

    set_assoc_cache dut (
        .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req), .wr_be(wr_be), .wr_data(wr_data),
        .rd_data(rd_data), .miss(miss), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
        .mem_addr(mem_addr), .mem_wr_line(mem_wr_line), .mem_rd_line(mem_rd_line), .mem_gnt(mem_gnt)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] init_line(input int l);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = 32'hA000_0000 + 32'(l * 8 + k);
        return r;
    endfunction

    function automatic int clean_miss();
        return 3 + gnt_delay;
    endfunction

    function automatic int dirty_miss();
        return 4 + 2 * gnt_delay;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_rd(input logic [8:0] la);
        mreq_t m;
        m.wr = 1'b0; m.laddr = la; m.line = '0;
        mreq_q.push_back(m);
    endtask

    task automatic exp_wr(input logic [8:0] la, input logic [255:0] line);
        mreq_t m;
        m.wr = 1'b1; m.laddr = la; m.line = line;
        mreq_q.push_back(m);
    endtask

    task automatic check_mreq(input logic is_wr);
        mreq_t m;
        if (mreq_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_mem_req: got wr=%0b addr=%0h expected none", is_wr, mem_addr);
        end else begin
            m = mreq_q.pop_front();
            check("mem_req_kind", 256'(is_wr), 256'(m.wr));
            check("mem_addr", 256'(mem_addr), 256'(m.laddr));
            if (is_wr) check("mem_wr_line", mem_wr_line, m.line);
        end
    endtask

    task automatic access(input logic [31:0] a, input logic rd, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] exp_data, input int exp_miss);
        rsp_t e;
        int   n;
        e.data = exp_data; e.miss_cycles = exp_miss;
        rsp_q.push_back(e);
        @(posedge clk); #1;
        addr = a; rd_req = rd; wr_be = be; wr_data = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (miss && n < 300);
        if (miss) begin
            total++; bad++;
            $display("FAIL access_timeout: addr %0h still missing, expected service", a);
        end
        @(posedge clk); #1;
        rd_req = 1'b0; wr_be = 4'h0;
    endtask

    // memory responder: grants gnt_delay cycles after the request is first seen
    initial begin
        for (int l = 0; l < 512; l++) mem_arr[l] = init_line(l);
        mem_gnt = 1'b0; mem_rd_line = '0;
        forever begin
            @(posedge clk); #1;
            mem_gnt = 1'b0;
            if (mem_rd_req || mem_wr_req) begin
                wait_cnt++;
                if (wait_cnt > gnt_delay) begin
                    mem_gnt = 1'b1;
                    wait_cnt = 0;
                    if (mem_wr_req) mem_arr[mem_addr] = mem_wr_line;
                    else mem_rd_line = mem_arr[mem_addr];
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // monitor: counts stall cycles, checks served responses and new memory requests
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rd = 1'b0; prev_wr = 1'b0;
            end else begin
                if (rd_req || (wr_be != 4'h0)) begin
                    if (miss) begin
                        miss_cnt++;
                    end else begin
                        if (rsp_q.size() == 0) begin
                            total++; bad++;
                            $display("FAIL unexpected_response: got rd_data %0h expected none", rd_data);
                        end else begin
                            e = rsp_q.pop_front();
                            check("rd_data", 256'(rd_data), 256'(e.data));
                            if (e.miss_cycles >= 0) check("miss_cycles", 256'(miss_cnt), 256'(e.miss_cycles));
                        end
                        miss_cnt = 0;
                    end
                end
                if (mem_wr_req && !prev_wr) check_mreq(1'b1);
                if (mem_rd_req && !prev_rd) check_mreq(1'b0);
                prev_wr = mem_wr_req;
                prev_rd = mem_rd_req;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; addr = 32'h0; rd_req = 1'b0; wr_be = 4'h0; wr_data = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_mem_rd_req", 256'(mem_rd_req), 256'(1'b0));
        check("rst_mem_wr_req", 256'(mem_wr_req), 256'(1'b0));
        check("rst_mem_addr", 256'(mem_addr), 256'(9'h0));
        check("rst_mem_wr_line", mem_wr_line, 256'h0);
        check("rst_rd_data", 256'(rd_data), 256'(32'h0));
        check("rst_miss_idle", 256'(miss), 256'(1'b0));
        addr = 32'h10; rd_req = 1'b1; #1;
        check("rst_miss_req", 256'(miss), 256'(1'b1));
        rd_req = 1'b0;
        @(negedge clk); rst = 1'b0;

        // clean read miss, then partial write hit and read/write collision
        exp_rd(9'd0);
        access(32'h10, 1'b1, 4'h0, 32'h0, 32'hA000_0004, clean_miss());
        access(32'h10, 1'b0, 4'hF, 32'h1122_3344, 32'h0, 0);
        access(32'h10, 1'b0, 4'b0010, 32'h0000_AB00, 32'h0, 0);
        access(32'h10, 1'b1, 4'h0, 32'h0, 32'h1122_AB44, 0);
        access(32'h14, 1'b1, 4'hF, 32'h5555_6666, 32'hA000_0005, 0);
        access(32'h14, 1'b1, 4'h0, 32'h0, 32'h5555_6666, 0);

        // fill set 0, then a fifth tag forces write-back of the dirty tag-0 line
        exp_rd(9'd8);  access(32'h100, 1'b1, 4'h0, 32'h0, 32'hA000_0040, clean_miss());
        exp_rd(9'd16); access(32'h200, 1'b1, 4'h0, 32'h0, 32'hA000_0080, clean_miss());
        exp_rd(9'd24); access(32'h300, 1'b1, 4'h0, 32'h0, 32'hA000_00C0, clean_miss());
        exp_line = init_line(0);
        exp_line[4*32 +: 32] = 32'h1122_AB44;
        exp_line[5*32 +: 32] = 32'h5555_6666;
        exp_wr(9'd0, exp_line);
        exp_rd(9'd32); access(32'h400, 1'b1, 4'h0, 32'h0, 32'hA000_0100, dirty_miss());
        exp_rd(9'd0);  access(32'h10, 1'b1, 4'h0, 32'h0, 32'h1122_AB44, clean_miss());

        // replacement policy in set 1 with zero-latency grants
        gnt_delay = 0;
        exp_rd(9'd9);  access(32'h120, 1'b1, 4'h0, 32'h0, 32'hA000_0048, clean_miss());
        exp_rd(9'd17); access(32'h220, 1'b1, 4'h0, 32'h0, 32'hA000_0088, clean_miss());
        exp_rd(9'd25); access(32'h320, 1'b1, 4'h0, 32'h0, 32'hA000_00C8, clean_miss());
        exp_rd(9'd33); access(32'h420, 1'b1, 4'h0, 32'h0, 32'hA000_0108, clean_miss());
        access(32'h120, 1'b1, 4'h0, 32'h0, 32'hA000_0048, 0);
        exp_rd(9'd41); access(32'h520, 1'b1, 4'h0, 32'h0, 32'hA000_0148, clean_miss());
`ifdef CACHE_LRU_EN
        access(32'h120, 1'b1, 4'h0, 32'h0, 32'hA000_0048, 0);
`else
        exp_rd(9'd9);  access(32'h120, 1'b1, 4'h0, 32'h0, 32'hA000_0048, clean_miss());
`endif
        exp_rd(9'd17); access(32'h220, 1'b1, 4'h0, 32'h0, 32'hA000_0088, clean_miss());

        // reset while waiting for the refill grant
        gnt_delay = 20;
        exp_rd(9'd1);
        @(posedge clk); #1;
        addr = 32'h28; rd_req = 1'b1;
        repeat (3) @(negedge clk);
        check("swap_in_rd_req", 256'(mem_rd_req), 256'(1'b1));
        #2 rst = 1'b1;
        #1;
        check("abort_rd_req_async", 256'(mem_rd_req), 256'(1'b0));
        check("abort_miss_formula", 256'(miss), 256'(1'b1));
        rd_req = 1'b0;
        miss_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        gnt_delay = 2;
        exp_rd(9'd1); access(32'h28, 1'b1, 4'h0, 32'h0, 32'hA000_000A, clean_miss());

        // write miss allocates, write lands, line later written back dirty
        exp_rd(9'd2);  access(32'h40, 1'b0, 4'hF, 32'hDEAD_BEEF, 32'h0, clean_miss());
        access(32'h40, 1'b1, 4'h0, 32'h0, 32'hDEAD_BEEF, 0);
        exp_rd(9'd10); access(32'h140, 1'b1, 4'h0, 32'h0, 32'hA000_0050, clean_miss());
        exp_rd(9'd18); access(32'h240, 1'b1, 4'h0, 32'h0, 32'hA000_0090, clean_miss());
        exp_rd(9'd26); access(32'h340, 1'b1, 4'h0, 32'h0, 32'hA000_00D0, clean_miss());
        exp_line = init_line(2);
        exp_line[31:0] = 32'hDEAD_BEEF;
        exp_wr(9'd2, exp_line);
        exp_rd(9'd34); access(32'h440, 1'b1, 4'h0, 32'h0, 32'hA000_0110, dirty_miss());

        repeat (2) @(negedge clk);
        check("rsp_q_drained", 256'(rsp_q.size()), 256'(0));
        check("mreq_q_drained", 256'(mreq_q.size()), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
